// File: rtl/l15_noc1_out_sched_if.sv
// rtl/l15_noc1_out_sched_if.sv - val/rdy bundle for the two NoC1 flit sources and the router port
interface l15_noc1_out_sched_if #(
  parameter int FLIT_W = 64
);
  logic              src0_val;
  logic [FLIT_W-1:0] src0_data;
  logic              src0_rdy;
  logic              src1_val;
  logic [FLIT_W-1:0] src1_data;
  logic              src1_rdy;
  logic              noc1_out_val;
  logic [FLIT_W-1:0] noc1_out_data;
  logic              noc1_out_rdy;

  modport master (
    output src0_val, src0_data, src1_val, src1_data, noc1_out_rdy,
    input  src0_rdy, src1_rdy, noc1_out_val, noc1_out_data
  );

  modport slave (
    input  src0_val, src0_data, src1_val, src1_data, noc1_out_rdy,
    output src0_rdy, src1_rdy, noc1_out_val, noc1_out_data
  );
endinterface

// File: rtl/l15_noc1_out_sched.sv
// rtl/l15_noc1_out_sched.sv - packet-granular round-robin scheduler for the L1.5 NoC1 output port
module l15_noc1_out_sched #(
  parameter int FLIT_W = 64,
  parameter int LEN_LO = 22,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dmbr_l15_stall,
  l15_noc1_out_sched_if.slave     bus,
  output logic                    sched_busy,
  output logic                    sched_owner
);
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_rr_ptr, w_rr_nxt;
  logic [LEN_W-1:0]  r_remaining, w_rem_nxt;

  logic              w_pick, w_sel, w_sel_val, w_hs;
  logic [FLIT_W-1:0] w_sel_data;
  logic [LEN_W-1:0]  w_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_remaining <= w_rem_nxt;
    end
  end

  // Source pick: owner while sending, otherwise rr_ptr first; reset masks everything.
  always_comb begin
    w_pick = 1'b0;
    w_sel  = r_rr_ptr;
    if (!rst) begin
      if (r_state == S_SEND) begin
        w_pick = 1'b1;
        w_sel  = r_owner;
      end else if (!dmbr_l15_stall) begin
        if (r_rr_ptr ? bus.src1_val : bus.src0_val) begin
          w_pick = 1'b1;
          w_sel  = r_rr_ptr;
        end else if (r_rr_ptr ? bus.src0_val : bus.src1_val) begin
          w_pick = 1'b1;
          w_sel  = ~r_rr_ptr;
        end
      end
    end
    w_sel_val  = w_sel ? bus.src1_val  : bus.src0_val;
    w_sel_data = w_sel ? bus.src1_data : bus.src0_data;
  end

  assign bus.noc1_out_val  = w_pick & w_sel_val;
  assign bus.noc1_out_data = (w_pick && w_sel_val) ? w_sel_data : '0;
  assign bus.src0_rdy      = w_pick & ~w_sel & bus.noc1_out_rdy;
  assign bus.src1_rdy      = w_pick &  w_sel & bus.noc1_out_rdy;
  assign sched_busy        = (r_state == S_SEND);
  assign sched_owner       = r_owner;

  assign w_hs  = bus.noc1_out_val & bus.noc1_out_rdy;
  assign w_len = w_sel_data[LEN_LO +: LEN_W];

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_rem_nxt   = r_remaining;
    if (w_hs) begin
      if (r_state == S_IDLE) begin
        if (w_len == '0) begin
          w_rr_nxt = ~w_sel;
        end else begin
          w_state_nxt = S_SEND;
          w_owner_nxt = w_sel;
          w_rem_nxt   = w_len;
        end
      end else begin
        w_rem_nxt = r_remaining - LEN_W'(1);
        if (r_remaining == LEN_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = ~r_owner;
        end
      end
    end
  end
endmodule

// File: tb/tb_l15_noc1_out_sched.sv
// tb/tb_l15_noc1_out_sched.sv - directed self-checking bench for l15_noc1_out_sched
module tb_l15_noc1_out_sched;
  typedef logic [63:0] flit_q_t[$];

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic sched_busy, sched_owner;
  always #5 clk = ~clk;

  l15_noc1_out_sched_if #(.FLIT_W(64)) bus ();

  l15_noc1_out_sched #(.FLIT_W(64), .LEN_LO(22), .LEN_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .dmbr_l15_stall (stall),
    .bus            (bus),
    .sched_busy     (sched_busy),
    .sched_owner    (sched_owner)
  );

  flit_q_t     q0, q1, log_q, exp_q;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        obs_val, obs_rdy0, obs_rdy1;
  logic [63:0] obs_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] id, input logic [7:0] len);
    logic [63:0] h;
    h = {id, 56'h0};
    h[29:22] = len;
    return h;
  endfunction

  function automatic logic [63:0] pay(input logic [7:0] id, input logic [7:0] n);
    return {id, 8'hEE, 40'h0, n};
  endfunction

  // One clock: sources present queue heads, sample mid-cycle, retire handshakes.
  task automatic step(input logic rdy);
    bus.noc1_out_rdy = rdy;
    bus.src0_val  = (q0.size() != 0);
    bus.src0_data = (q0.size() != 0) ? q0[0] : 64'h0;
    bus.src1_val  = (q1.size() != 0);
    bus.src1_data = (q1.size() != 0) ? q1[0] : 64'h0;
    #4;
    obs_val  = bus.noc1_out_val;
    obs_data = bus.noc1_out_data;
    obs_rdy0 = bus.src0_rdy;
    obs_rdy1 = bus.src1_rdy;
    if (!rst) begin
      if (bus.src0_val && bus.src0_rdy) void'(q0.pop_front());
      if (bus.src1_val && bus.src1_rdy) void'(q1.pop_front());
      if (bus.noc1_out_val && bus.noc1_out_rdy) log_q.push_back(bus.noc1_out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input flit_q_t exp);
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), log_q[i], exp[i]);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    bus.noc1_out_rdy = 1'b1;
    bus.src0_val = 1'b0; bus.src0_data = '0;
    bus.src1_val = 1'b0; bus.src1_data = '0;
    @(posedge clk);
    #1;

    // Reset holds outputs low even with src0 valid, then zero-latency pick
    q0 = {hdr(8'hA0, 8'd0)};
    step(1'b1);
    check("rst_out_val", 64'(obs_val), 64'd0);
    check("rst_src0_rdy", 64'(obs_rdy0), 64'd0);
    check("rst_busy", 64'(sched_busy), 64'd0);
    rst = 1'b0;
    step(1'b1);
    check("first_val", 64'(obs_val), 64'd1);
    check("first_data", obs_data, hdr(8'hA0, 8'd0));
    check("first_src0_rdy", 64'(obs_rdy0), 64'd1);
    check("single_busy", 64'(sched_busy), 64'd0);
    check("single_rr", 64'(dut.r_rr_ptr), 64'd1);
    exp_q = {hdr(8'hA0, 8'd0)};
    check_log("single", exp_q);

    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("rst_rr_clear", 64'(dut.r_rr_ptr), 64'd0);

    // Contention: src0 packet wins, then src1, no interleave, no bubbles
    log_q.delete();
    q0 = {hdr(8'hB0, 8'd2), pay(8'hB0, 8'd1), pay(8'hB0, 8'd2)};
    q1 = {hdr(8'hC1, 8'd1), pay(8'hC1, 8'd1)};
    step(1'b1);
    check("cont_busy", 64'(sched_busy), 64'd1);
    check("cont_owner0", 64'(sched_owner), 64'd0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("cont_owner1", 64'(sched_owner), 64'd1);
    step(1'b1);
    exp_q = {hdr(8'hB0, 8'd2), pay(8'hB0, 8'd1), pay(8'hB0, 8'd2),
             hdr(8'hC1, 8'd1), pay(8'hC1, 8'd1)};
    check_log("cont", exp_q);
    check("cont_idle", 64'(sched_busy), 64'd0);

    // Backpressure: data stays put while router is not ready
    log_q.delete();
    q1 = {hdr(8'hD1, 8'd3), pay(8'hD1, 8'd1), pay(8'hD1, 8'd2), pay(8'hD1, 8'd3)};
    step(1'b1);
    step(1'b0);
    check("bp_hold0_val", 64'(obs_val), 64'd1);
    check("bp_hold0_data", obs_data, pay(8'hD1, 8'd1));
    step(1'b0);
    check("bp_hold1_data", obs_data, pay(8'hD1, 8'd1));
    step(1'b1);
    step(1'b1);
    step(1'b1);
    exp_q = {hdr(8'hD1, 8'd3), pay(8'hD1, 8'd1), pay(8'hD1, 8'd2), pay(8'hD1, 8'd3)};
    check_log("bp", exp_q);
    check("bp_idle", 64'(sched_busy), 64'd0);

    // Stall blocks packet start only
    log_q.delete();
    stall = 1'b1;
    q0 = {hdr(8'hE0, 8'd2), pay(8'hE0, 8'd1), pay(8'hE0, 8'd2)};
    step(1'b1);
    check("stall_idle_val", 64'(obs_val), 64'd0);
    check("stall_idle_rdy0", 64'(obs_rdy0), 64'd0);
    step(1'b1);
    check("stall_idle_val2", 64'(obs_val), 64'd0);
    stall = 1'b0;
    step(1'b1);
    stall = 1'b1;
    step(1'b1);
    check("stall_send_val", 64'(obs_val), 64'd1);
    step(1'b1);
    stall = 1'b0;
    exp_q = {hdr(8'hE0, 8'd2), pay(8'hE0, 8'd1), pay(8'hE0, 8'd2)};
    check_log("stall", exp_q);
    check("stall_rr", 64'(dut.r_rr_ptr), 64'd1);

    // Reset mid-packet abandons it; a fresh src1 packet goes through
    log_q.delete();
    q0 = {hdr(8'hF0, 8'd4), pay(8'hF0, 8'd1), pay(8'hF0, 8'd2), pay(8'hF0, 8'd3), pay(8'hF0, 8'd4)};
    step(1'b1);
    step(1'b1);
    check("midrst_busy_pre", 64'(sched_busy), 64'd1);
    rst = 1'b1;
    step(1'b1);
    check("midrst_val", 64'(obs_val), 64'd0);
    check("midrst_busy", 64'(sched_busy), 64'd0);
    check("midrst_rr", 64'(dut.r_rr_ptr), 64'd0);
    q0.delete();
    log_q.delete();
    rst = 1'b0;
    q1 = {hdr(8'h91, 8'd1), pay(8'h91, 8'd1)};
    step(1'b1);
    check("midrst_new_owner", 64'(sched_owner), 64'd1);
    step(1'b1);
    exp_q = {hdr(8'h91, 8'd1), pay(8'h91, 8'd1)};
    check_log("midrst_new", exp_q);
    check("midrst_end_busy", 64'(sched_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
